// File: rtl/rf_load_ctrl.sv
// rf_load_ctrl: load/drain sequencer for the systolic-array register file.
// Takes a stream of matrix elements over valid/ready and turns them into RF
// write controls with diagonal skew. It then issues one commit rewrite,
// runs the drain phase that shifts RF contents into the array, and pulses DONE.
//
// Timing: every output is a register. IN_READY and RF_EN are loaded from the
// state being entered, so the handshake lines up with the LOAD state. WRITE,
// REG_SELECT, IDX and DIN show a beat on the edge after it is accepted.
// BUSY, DRAIN_ACTIVE and DONE are loaded from the state being left, so DONE
// shows on the edge that leaves FIN and BUSY is still high alongside it.
module rf_load_ctrl #(
    parameter int DATA_W       = 16,
    parameter int N            = 8,
    parameter int SEL_W        = 4,
    parameter int IDX_W        = 5,
    parameter int DRAIN_CYCLES = 25
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              DRAIN_ACTIVE,
    output logic              RF_EN,
    output logic              WRITE,
    output logic [SEL_W-1:0]  REG_SELECT,
    output logic [IDX_W-1:0]  IDX,
    output logic [DATA_W-1:0] DIN
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [SEL_W-1:0]   LAST_REG   = SEL_W'(2 * N - 1);
    localparam logic [SEL_W-1:0]   N_SEL      = SEL_W'(N);
    localparam logic [IDX_W-1:0]   LAST_ELEM  = IDX_W'(N - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [SEL_W-1:0]    reg_cnt, reg_cnt_d;
    logic [IDX_W-1:0]    elem_cnt, elem_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_d;

    logic                in_ready_d, busy_d, done_d, drain_active_d, rf_en_d, write_d;
    logic [SEL_W-1:0]    reg_select_d;
    logic [IDX_W-1:0]    idx_d;
    logic [DATA_W-1:0]   din_d;

    logic [SEL_W-1:0]    reg_lo;
    logic [IDX_W-1:0]    idx_calc;
    logic                accept;
    logic                last_beat;

    // Skew term: registers 0..N-1 (X) and N..2N-1 (W) get the same diagonal offset.
    assign reg_lo    = (reg_cnt >= N_SEL) ? (reg_cnt - N_SEL) : reg_cnt;
    assign idx_calc  = elem_cnt + IDX_W'(reg_lo) + IDX_W'(1);
    assign accept    = (state == LOAD) && IN_VALID && IN_READY;
    assign last_beat = (reg_cnt == LAST_REG) && (elem_cnt == LAST_ELEM);

    // Next-state, counter and next-output decode.
    always_comb begin
        state_d        = state;
        reg_cnt_d      = reg_cnt;
        elem_cnt_d     = elem_cnt;
        drain_cnt_d    = drain_cnt;
        in_ready_d     = 1'b0;
        rf_en_d        = 1'b0;
        write_d        = 1'b0;
        reg_select_d   = REG_SELECT;
        idx_d          = IDX;
        din_d          = DIN;
        busy_d         = (state != IDLE);
        done_d         = 1'b0;
        drain_active_d = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    state_d     = LOAD;
                    in_ready_d  = 1'b1;
                    rf_en_d     = 1'b1;
                    reg_cnt_d   = '0;
                    elem_cnt_d  = '0;
                    drain_cnt_d = '0;
                end
            end
            LOAD: begin
                in_ready_d = 1'b1;
                rf_en_d    = 1'b1;
                if (accept) begin
                    write_d      = 1'b1;
                    reg_select_d = reg_cnt;
                    idx_d        = idx_calc;
                    din_d        = IN_DATA;
                    if (last_beat) begin
                        state_d    = FLUSH;
                        in_ready_d = 1'b0;
                    end else if (elem_cnt == LAST_ELEM) begin
                        elem_cnt_d = '0;
                        reg_cnt_d  = reg_cnt + SEL_W'(1);
                    end else begin
                        elem_cnt_d = elem_cnt + IDX_W'(1);
                    end
                end
            end
            FLUSH: begin
                write_d     = 1'b1;
                rf_en_d     = 1'b1;
                drain_cnt_d = '0;
                state_d     = DRAIN;
            end
            DRAIN: begin
                rf_en_d        = 1'b1;
                drain_active_d = 1'b1;
                if (drain_cnt == LAST_DRAIN) begin
                    state_d = FIN;
                end else begin
                    drain_cnt_d = drain_cnt + DRAIN_W'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and all outputs; reset abandons any job in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            reg_cnt      <= '0;
            elem_cnt     <= '0;
            drain_cnt    <= '0;
            IN_READY     <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            DRAIN_ACTIVE <= 1'b0;
            RF_EN        <= 1'b0;
            WRITE        <= 1'b0;
            REG_SELECT   <= '0;
            IDX          <= '0;
            DIN          <= '0;
        end else begin
            state        <= state_d;
            reg_cnt      <= reg_cnt_d;
            elem_cnt     <= elem_cnt_d;
            drain_cnt    <= drain_cnt_d;
            IN_READY     <= in_ready_d;
            BUSY         <= busy_d;
            DONE         <= done_d;
            DRAIN_ACTIVE <= drain_active_d;
            RF_EN        <= rf_en_d;
            WRITE        <= write_d;
            REG_SELECT   <= reg_select_d;
            IDX          <= idx_d;
            DIN          <= din_d;
        end
    end

endmodule

// File: tb/tb_rf_load_ctrl.sv
// tb_rf_load_ctrl: scoreboard bench for rf_load_ctrl.
// The driver pushes the expected RF writes and DONE edges into queues as it starts
// each job. A free-running monitor pops those queues and compares them on every
// WRITE and DONE, and checks that outputs hold in cycles with no write.
module tb_rf_load_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [15:0] IN_DATA = '0;
    logic        IN_READY, BUSY, DONE, DRAIN_ACTIVE, RF_EN, WRITE;
    logic [3:0]  REG_SELECT;
    logic [4:0]  IDX;
    logic [15:0] DIN;

    typedef struct {
        logic [3:0]  sel;
        logic [4:0]  idx;
        logic [15:0] din;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    wr_t last_wr;
    bit  have_last = 1'b0;
    int  drain_seen = 0;
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    rf_load_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .IN_DATA(IN_DATA), .BUSY(BUSY), .DONE(DONE),
        .DRAIN_ACTIVE(DRAIN_ACTIVE), .RF_EN(RF_EN), .WRITE(WRITE),
        .REG_SELECT(REG_SELECT), .IDX(IDX), .DIN(DIN)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] beat_data(input int b);
        return 16'(((b / 8) * 16) + (b % 8));
    endfunction

    // Expected write for beat b: register b/8, element b%8, skewed by register mod 8.
    function automatic wr_t beat_write(input int b);
        wr_t w;
        int  r, e;
        r = b / 8;
        e = b % 8;
        w.sel = 4'(r);
        w.idx = 5'(e + (r % 8) + 1);
        w.din = beat_data(b);
        return w;
    endfunction

    // Monitor: outputs registered at edge cyc are sampled 1 time unit after it.
    initial begin
        wr_t w;
        int  exp_edge;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (RST) begin
                have_last  = 1'b0;
                drain_seen = 0;
            end else begin
                if (WRITE) begin
                    if (wr_q.size() == 0) begin
                        check_output("unexpected_write", WRITE, 0);
                    end else begin
                        w = wr_q.pop_front();
                        check_output("write_sel", REG_SELECT, w.sel);
                        check_output("write_idx", IDX, w.idx);
                        check_output("write_din", DIN, w.din);
                        last_wr   = w;
                        have_last = 1'b1;
                    end
                end else if (have_last) begin
                    check_output("hold_sel", REG_SELECT, last_wr.sel);
                    check_output("hold_idx", IDX, last_wr.idx);
                    check_output("hold_din", DIN, last_wr.din);
                end
                if (DRAIN_ACTIVE) begin
                    drain_seen++;
                    check_output("drain_rf_en", RF_EN, 1);
                end
                if (DONE) begin
                    if (done_q.size() == 0) begin
                        check_output("unexpected_done", DONE, 0);
                    end else begin
                        exp_edge = done_q.pop_front();
                        check_output("done_edge", cyc, exp_edge);
                        check_output("drain_cycles", drain_seen, 25);
                        check_output("done_busy", BUSY, 1);
                        check_output("done_rf_en", RF_EN, 0);
                    end
                    drain_seen = 0;
                end
            end
        end
    end

    // One job, entered and left at a negedge. gap_every>0 drops IN_VALID every
    // gap_every-th load cycle; with_beat offers a junk beat alongside START;
    // pulse_start strobes START during LOAD and DRAIN; abort_after>0 resets mid-job.
    task automatic apply_stimulus(input int gap_every, input bit with_beat,
                                  input bit pulse_start, input int abort_after);
        int  b, k, idles, guard, t, start_edge;
        bit  valid, accepted;
        b = 0; k = 0; idles = 0; guard = 0;

        START      = 1'b1;
        IN_VALID   = with_beat;
        IN_DATA    = 16'hDEAD;
        start_edge = cyc + 1;
        for (int i = 0; i < 128; i++) wr_q.push_back(beat_write(i));
        wr_q.push_back(beat_write(127));
        @(negedge CLK);
        START = 1'b0;
        check_output("busy_start_edge", BUSY, 0);
        check_output("ready_in_load", IN_READY, 1);

        while (b < 128 && guard < 2000) begin
            if (abort_after > 0 && b == abort_after) begin
                IN_VALID = 1'b0;
                RST      = 1'b1;
                wr_q.delete();
                @(posedge CLK);
                #1;
                check_output("rst_write", WRITE, 0);
                check_output("rst_sel", REG_SELECT, 0);
                check_output("rst_idx", IDX, 0);
                check_output("rst_din", DIN, 0);
                check_output("rst_ready", IN_READY, 0);
                check_output("rst_busy", BUSY, 0);
                check_output("rst_rf_en", RF_EN, 0);
                check_output("rst_done", DONE, 0);
                check_output("rst_drain", DRAIN_ACTIVE, 0);
                @(negedge CLK);
                RST = 1'b0;
                @(negedge CLK);
                check_output("idle_after_rst_busy", BUSY, 0);
                check_output("idle_after_rst_ready", IN_READY, 0);
                return;
            end
            if (k == 1) check_output("busy_in_load", BUSY, 1);
            valid    = !(gap_every > 0 && (k % gap_every) == gap_every - 1);
            START    = pulse_start && (k == 20);
            IN_VALID = valid;
            IN_DATA  = beat_data(b);
            if (!valid) idles++;
            accepted = valid && IN_READY;
            @(negedge CLK);
            if (accepted) b++;
            k++;
            guard++;
        end
        IN_VALID = 1'b0;
        START    = 1'b0;
        if (b < 128) check_output("load_timeout", b, 128);
        done_q.push_back(start_edge + 155 + idles);

        if (pulse_start) begin
            repeat (5) @(negedge CLK);
            START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
        end

        t = 0;
        while (done_q.size() != 0 && t < 400) begin
            @(negedge CLK);
            t++;
        end
        check_output("done_timeout", done_q.size(), 0);
        done_q.delete();
        check_output("writes_left", wr_q.size(), 0);
        wr_q.delete();
        check_output("busy_at_done", BUSY, 1);
    endtask

    // Stimulus sequence.
    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_output("reset_write", WRITE, 0);
        check_output("reset_ready", IN_READY, 0);
        check_output("reset_busy", BUSY, 0);
        check_output("reset_done", DONE, 0);
        check_output("reset_drain", DRAIN_ACTIVE, 0);
        check_output("reset_rf_en", RF_EN, 0);
        check_output("reset_sel", REG_SELECT, 0);
        check_output("reset_idx", IDX, 0);
        check_output("reset_din", DIN, 0);
        RST = 1'b0;
        @(negedge CLK);

        $display("[TB] full job, IN_VALID held high");
        apply_stimulus(0, 1'b0, 1'b0, 0);
        $display("[TB] back-to-back job with IN_VALID low every third cycle");
        apply_stimulus(3, 1'b0, 1'b0, 0);
        repeat (4) @(negedge CLK);
        $display("[TB] START pulsed during LOAD and DRAIN");
        apply_stimulus(0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge CLK);
        check_output("no_restart_busy", BUSY, 0);
        $display("[TB] beat offered together with START");
        apply_stimulus(0, 1'b1, 1'b0, 0);
        repeat (3) @(negedge CLK);
        $display("[TB] reset after 40 beats");
        apply_stimulus(0, 1'b0, 1'b0, 40);
        $display("[TB] restart after reset, then back-to-back repeat");
        apply_stimulus(0, 1'b0, 1'b0, 0);
        apply_stimulus(0, 1'b0, 1'b0, 0);

        repeat (20) @(negedge CLK);
        check_output("final_busy", BUSY, 0);
        check_output("final_ready", IN_READY, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_load_ctrl.md
Name: rf_load_ctrl

Overview:
- Sequencer for the systolic-array register file (16 registers: 0-7 feed X, 8-15 feed W).
- Accepts a stream of matrix elements over a valid/ready handshake and generates the RF write controls (REG_SELECT, IDX, DIN, WRITE) with diagonal skew.
- Issues the single commit cycle the RF's write buffer needs, runs the drain phase that shifts RF contents into the array, then pulses DONE.

Parameters:
- DATA_W, 16, element width.
- N, 8, array dimension; also elements per register. Register count is 2N.
- SEL_W, 4, REG_SELECT width; must satisfy 2^SEL_W >= 2N.
- IDX_W, 5, RF element index width; must hold 2N.
- DRAIN_CYCLES, 25, number of read/shift cycles in the drain phase.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  begin one load/drain job; sampled only in IDLE.
- IN_VALID  in  1  element beat valid.
- IN_READY  out  1  controller accepts a beat.
- IN_DATA  in  DATA_W  element value.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- DRAIN_ACTIVE  out  1  high during drain cycles.
- RF_EN  out  1  RF enable.
- WRITE  out  1  RF write strobe.
- REG_SELECT  out  SEL_W  target register.
- IDX  out  IDX_W  target element index.
- DIN  out  DATA_W  write data.

Behaviour:
- One clock (CLK); reset (RST) is synchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0. The state machine and the counters reg_cnt, elem_cnt and drain_cnt are also 0.
- RST mid-job: the next edge forces IDLE and zeroes every output, with no flush or drain. The RF is left partially written.
- States: IDLE, LOAD, FLUSH, DRAIN, FIN.
- IDLE:
  - IN_READY=0, RF_EN=0, WRITE=0.
  - START=1 moves to LOAD on the next edge.
  - A beat presented in the same cycle as START is not accepted.
- LOAD:
  - IN_READY=1 and RF_EN=1.
  - A beat is accepted when IN_VALID & IN_READY.
  - On the edge after acceptance: WRITE=1, REG_SELECT=reg_cnt, IDX=elem_cnt + (reg_cnt mod N) + 1, DIN=IN_DATA.
  - Counters then advance: elem_cnt 0..N-1; on wrap, reg_cnt increments.
  - Beat order: register 0 elements 0..N-1, then register 1, ..., up to register 2N-1.
  - In a cycle with no accepted beat, WRITE=0 on the next edge, counters hold, and REG_SELECT/IDX/DIN hold their last values.
  - IDX range is 1..2N-1, with no overflow.
  - The last beat (reg_cnt=2N-1, elem_cnt=N-1) moves to FLUSH, with IN_READY=0 from that edge onward.
- FLUSH (exactly 1 cycle):
  - WRITE=1, with REG_SELECT/IDX/DIN repeating the last beat. This is an idempotent rewrite that commits the RF input buffer.
  - Then moves to DRAIN.
- DRAIN:
  - WRITE=0, RF_EN=1, DRAIN_ACTIVE=1.
  - drain_cnt counts 0..DRAIN_CYCLES-1; after DRAIN_CYCLES cycles, moves to FIN.
- FIN (1 cycle):
  - DONE=1, BUSY=1, RF_EN=0, DRAIN_ACTIVE=0.
  - Then moves to IDLE.
  - DONE is never high for two consecutive cycles.
- START outside IDLE is ignored; it is not queued.
- IN_VALID outside LOAD is ignored.
- Minimum job latency with IN_VALID held high:
  - START sampled at cycle 0.
  - LOAD is cycles 1..2N*N.
  - FLUSH is cycle 2N*N+1.
  - DRAIN is the next DRAIN_CYCLES cycles.
  - With default parameters, DONE is at cycle 2N*N + DRAIN_CYCLES + 2 = 155.

Test Plan:
- Full job, IN_VALID always high, IN_DATA = reg*16 + elem:
  - Exactly 128 LOAD writes plus 1 FLUSH write.
  - The beat for reg 3 / elem 2 produces REG_SELECT=3, IDX=6, DIN=0x0032.
  - The beat for reg 10 / elem 0 produces REG_SELECT=10, IDX=3, DIN=0x00A0.
  - FLUSH repeats REG_SELECT=15, IDX=15, DIN=0x00F7.
  - DRAIN_ACTIVE is high for 25 cycles; DONE is at cycle 155 only.
- Backpressure: IN_VALID low on every third cycle:
  - Each idle cycle produces WRITE=0 with REG_SELECT/IDX/DIN held.
  - The write sequence is identical to the first test.
  - DONE is delayed by exactly the number of idle cycles.
- START pulsed during LOAD and during DRAIN -> no restart, and exactly one DONE pulse.
- START together with IN_VALID in IDLE -> that beat is not written, and the first write uses the second beat's data at REG_SELECT=0, IDX=1.
- RST asserted after 40 beats -> on the next edge all outputs are 0 and the state is IDLE. A new START then restarts at REG_SELECT=0, IDX=1.
- Back-to-back jobs with START asserted in the cycle after DONE -> the second job completes identically. BUSY is low for exactly that one IDLE cycle.
